// File: rtl/vga_disp_ctrl.sv
// vga_disp_ctrl: VGA timing generator, VRAM address issue, sync/RGB output stage
//   clk, rst           system clock, synchronous active-high reset
//   vram_addr[14:0]    row-major VRAM read address of the next active position
//   vram_rdata[11:0]   {R,G,B} from a 1-clk-latency synchronous RAM
//   hsync, vsync       sync pins, active level SYNC_POL
//   rdata/gdata/bdata  4-bit colour, forced to 0 in blanking
//   frame_start        1-clk pulse when the counters wrap to (0,0)
module vga_disp_ctrl #(
  parameter int   CLK_DIV  = 5,
  parameter int   H_ACT    = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACT    = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   SCALE_SH = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] vram_addr,
  input  logic [11:0] vram_rdata,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  rdata,
  output logic [3:0]  gdata,
  output logic [3:0]  bdata,
  output logic        frame_start
);
  localparam logic [3:0]  DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0]  HA      = 10'(H_ACT);
  localparam logic [9:0]  VA      = 10'(V_ACT);
  localparam logic [9:0]  H_MAX   = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_MAX   = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  HS0     = 10'(H_ACT + H_FP);
  localparam logic [9:0]  HS1     = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0]  VS0     = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS1     = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [14:0] ROW_W   = 15'(H_ACT >> SCALE_SH);

  logic [3:0]  r_div;
  logic [9:0]  r_h, r_v;
  logic [14:0] r_addr;
  logic [11:0] r_rgb;
  logic        r_hs, r_vs, r_fs;
  logic        w_tick, w_h_wrap, w_v_wrap, w_act, w_act_nxt;
  logic [9:0]  w_h_nxt, w_v_nxt;
  logic [14:0] w_addr;

  always_comb begin
    w_tick    = r_div == DIV_MAX;
    w_h_wrap  = r_h == H_MAX;
    w_v_wrap  = r_v == V_MAX;
    w_h_nxt   = w_h_wrap ? '0 : r_h + 10'd1;
    w_v_nxt   = !w_h_wrap ? r_v : w_v_wrap ? '0 : r_v + 10'd1;
    w_act     = r_h < HA && r_v < VA;
    w_act_nxt = w_h_nxt < HA && w_v_nxt < VA;
    w_addr    = 15'(w_v_nxt >> SCALE_SH) * ROW_W + 15'(w_h_nxt >> SCALE_SH);
  end

  // The address is issued one tick ahead, so the RAM word present at the
  // following tick belongs to the position the output stage is emitting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_h    <= '0;
      r_v    <= '0;
      r_addr <= '0;
      r_rgb  <= '0;
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_fs   <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 4'd1;
      r_fs  <= w_tick && w_h_wrap && w_v_wrap;
      if (w_tick) begin
        r_h   <= w_h_nxt;
        r_v   <= w_v_nxt;
        r_rgb <= w_act ? vram_rdata : '0;
        r_hs  <= (r_h >= HS0 && r_h < HS1) ? SYNC_POL : ~SYNC_POL;
        r_vs  <= (r_v >= VS0 && r_v < VS1) ? SYNC_POL : ~SYNC_POL;
        if (w_act_nxt) r_addr <= w_addr;
      end
    end
  end

  assign vram_addr   = r_addr;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign rdata       = r_rgb[11:8];
  assign gdata       = r_rgb[7:4];
  assign bdata       = r_rgb[3:0];
  assign frame_start = r_fs;
endmodule

// File: doc/vga_disp_ctrl.md
Name: vga_disp_ctrl

Overview:
- Video output stage of the zedboard top: produces hsync, vsync, rdata, gdata and bdata from a scaled video RAM (VRAM).
- Generates 640x480@60 timing from the 125 MHz system clock using a pixel-tick divider.
- Issues VRAM read addresses, aligns the returned pixel data with sync, and forces RGB to 0 during blanking.
- Sits between the core-side VRAM read port and the board VGA pins.

Parameters:
- CLK_DIV, 5, system clocks per pixel (125 MHz / 5 = 25 MHz); legal range 2..15.
- H_ACT, 640, active pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACT, 480, active lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- SCALE_SH, 2, log2 of display pixels per VRAM pixel in each axis.
- SYNC_POL, 0, active level of hsync and vsync.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- vram_addr  out  15  VRAM read address, row-major: (v>>SCALE_SH)*(H_ACT>>SCALE_SH) + (h>>SCALE_SH)
- vram_rdata  in  12  pixel {R[11:8],G[7:4],B[3:0]}; synchronous RAM, valid 1 clk after vram_addr
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rdata  out  4  red
- gdata  out  4  green
- bdata  out  4  blue
- frame_start  out  1  1-clk pulse when the counters wrap to (0,0)

Behaviour:
- Reset: div_cnt=0, h_cnt=0, v_cnt=0, vram_addr=0, hsync=vsync=~SYNC_POL, rdata=gdata=bdata=0, frame_start=0.
  - Reset asserted mid-frame applies these values on the next clk edge.
  - The first pixel tick after reset is CLK_DIV clks after rst deasserts.
- Pixel tick: div_cnt counts 0..CLK_DIV-1; tick=1 in the clk where div_cnt==CLK_DIV-1, and div_cnt wraps to 0.
- Counters advance only on tick:
  - h_cnt counts 0..H_TOT-1, H_TOT=H_ACT+H_FP+H_SYNC+H_BP (800).
  - When h_cnt wraps, v_cnt increments, 0..V_TOT-1 with V_TOT=525.
  - Simultaneous wrap of both counters sets (0,0) and pulses frame_start in that same clk.
- Address: on tick, vram_addr is registered from the next (h,v) value.
  - When the next position is outside the active area, vram_addr is held.
  - vram_rdata therefore settles CLK_DIV-1 clks before the following tick.
- Output stage, on tick, from the pre-advance (h,v) value:
  - active = h<H_ACT && v<V_ACT.
  - {rdata,gdata,bdata} = active ? vram_rdata : 0.
  - hsync = SYNC_POL when H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC (490..491), else ~SYNC_POL.
- Latency: pins show the pixel at (h,v) exactly one pixel tick (CLK_DIV clks) after the counters reach (h,v). Sync and RGB stay aligned.
- Outputs are constant between ticks.
- Width rules:
  - Address multiply uses the constant H_ACT>>SCALE_SH (160); the maximum address is 19199, which fits in 15 bits.
  - Counters are 10 bits.
- No backpressure: VRAM must respond in 1 clk; rdata is sampled only at tick.

Test Plan:
- Reset: hold rst 3 clks mid-frame -> all outputs at reset values; first tick exactly 5 clks after release; h_cnt=1 after that tick.
- Line timing: run 2 lines -> hsync low for 96 ticks (480 clks) starting at h=656; line period 800 ticks (4000 clks); rgb=0 for h>=640.
- Frame timing: run one full frame -> vsync low during lines 490..491; frame period 525*800*5 = 2,100,000 clks; frame_start pulses once per frame.
- Addressing: VRAM model returns data=addr[11:0] -> at h=4,v=4 address=161; at h=639,v=479 address=19199; pins show the returned value one tick later.
- Alignment: VRAM all-white (12'hFFF) -> rdata/gdata/bdata=4'hF for exactly 640 ticks per active line, 0 in every blanking tick, including lines 480..524.
- CLK_DIV=2 build: same checks with all clk counts scaled by 2/5; data still correct with the 1-clk RAM latency.
